// File: rtl/ecc_pkg.sv
// Shared layout and Hamming position constants for the 40-bit SECDED word.
// The matching encoder uses the same constants.
package ecc_pkg;

    localparam int W_BITS    = 40;
    localparam int HALF_W    = 20;
    localparam int DATA_MSB  = 31;
    localparam int CHK_LSB   = 32;
    localparam int PAR_BIT   = 38;
    localparam int SPARE_BIT = 39;

    localparam logic [5:0] MAX_POS = 6'd38;

    // Codeword position of each data bit: the non-powers-of-two in 1..38, ascending.
    localparam logic [5:0] DATA_POS [0:31] = '{
        6'd3,  6'd5,  6'd6,  6'd7,  6'd9,  6'd10, 6'd11, 6'd12,
        6'd13, 6'd14, 6'd15, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd22, 6'd23, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd30, 6'd31, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38
    };

    typedef enum logic [1:0] {
        ECC_CLEAN,
        ECC_SEC,
        ECC_DED
    } ecc_class_e;

    // Codeword position of word bit j (0..37).
    function automatic logic [5:0] bit_pos(input int j);
        if (j <= DATA_MSB)
            return DATA_POS[j[4:0]];
        else
            return 6'(1 << (j - CHK_LSB));
    endfunction

endpackage

// File: rtl/ecc_secded_decoder_if.sv
// Raw read request and decoded word bus between the SRAM read port and the decoder.
interface ecc_secded_decoder_if
    import ecc_pkg::*;
#(
    parameter int ADDR_W = 16
);
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [HALF_W-1:0] raw_lo;
    logic [HALF_W-1:0] raw_hi;

    logic              out_valid;
    logic [HALF_W-1:0] data_lo_ecc;
    logic [HALF_W-1:0] data_hi_ecc;
    logic              sec;
    logic              ded;

    modport master (
        output rd_valid, rd_addr, raw_lo, raw_hi,
        input  out_valid, data_lo_ecc, data_hi_ecc, sec, ded
    );

    modport slave (
        input  rd_valid, rd_addr, raw_lo, raw_hi,
        output out_valid, data_lo_ecc, data_hi_ecc, sec, ded
    );
endinterface

// File: rtl/ecc_secded_syndrome.sv
// Combinational Hamming syndrome and overall parity of a 39-bit codeword.
// Encoder computes check bits by feeding zeros in the check/parity slots.
module ecc_secded_syndrome
    import ecc_pkg::*;
(
    input  logic [PAR_BIT:0] w,
    output logic [5:0]       syn,
    output logic             par
);

    always_comb begin
        syn = '0;
        for (int j = 0; j < PAR_BIT; j++) begin
            if (w[j])
                syn = syn ^ bit_pos(j);
        end
        par = ^w;
    end

endmodule

// File: rtl/ecc_secded_decoder.sv
// Two-stage SECDED decoder for the 40-bit SRAM word, with saturating
// error counters and first-DED address capture.
module ecc_secded_decoder
    import ecc_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 16
)
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              ecc_en_i,
    input  logic              cnt_clr_i,
    ecc_secded_decoder_if.slave bus,
    output logic [CNT_W-1:0]  sec_cnt_o,
    output logic [CNT_W-1:0]  ded_cnt_o,
    output logic [ADDR_W-1:0] ded_addr_o,
    output logic              ded_seen_o
);

    logic [W_BITS-1:0] w_in;
    logic [5:0]        syn_in;
    logic              par_in;

    logic              v1;
    logic              en1;
    logic [ADDR_W-1:0] addr1;
    logic [W_BITS-1:0] w1;
    logic [5:0]        s1;
    logic              p1;

    logic [ADDR_W-1:0] addr2;

    ecc_class_e        cls;
    logic [W_BITS-1:0] dec_word;

    assign w_in = {bus.raw_hi, bus.raw_lo};

    ecc_secded_syndrome u_syndrome (
        .w   (w_in[PAR_BIT:0]),
        .syn (syn_in),
        .par (par_in)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1    <= 1'b0;
            en1   <= 1'b0;
            addr1 <= '0;
            w1    <= '0;
            s1    <= '0;
            p1    <= 1'b0;
        end else begin
            v1 <= bus.rd_valid;
            if (bus.rd_valid) begin
                en1   <= ecc_en_i;
                addr1 <= bus.rd_addr;
                w1    <= w_in;
                s1    <= syn_in;
                p1    <= par_in;
            end
        end
    end

    // S=0 with P=1 means only the parity bit itself flipped.
    always_comb begin
        cls = ECC_CLEAN;
        if (p1 && (s1 <= MAX_POS))
            cls = ECC_SEC;
        else if (p1 || (s1 != '0))
            cls = ECC_DED;

        dec_word = w1;
        if (en1) begin
            dec_word[SPARE_BIT] = 1'b0;
            if (cls == ECC_SEC) begin
                if (s1 == '0) begin
                    dec_word[PAR_BIT] = ~w1[PAR_BIT];
                end else begin
                    for (int j = 0; j < PAR_BIT; j++) begin
                        if (bit_pos(j) == s1)
                            dec_word[j] = ~w1[j];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus.out_valid   <= 1'b0;
            bus.data_lo_ecc <= '0;
            bus.data_hi_ecc <= '0;
            bus.sec         <= 1'b0;
            bus.ded         <= 1'b0;
            addr2           <= '0;
        end else begin
            bus.out_valid <= v1;
            bus.sec       <= v1 && en1 && (cls == ECC_SEC);
            bus.ded       <= v1 && en1 && (cls == ECC_DED);
            if (v1) begin
                bus.data_lo_ecc <= dec_word[HALF_W-1:0];
                bus.data_hi_ecc <= dec_word[W_BITS-1:HALF_W];
                addr2           <= addr1;
            end
        end
    end

    // Clear takes priority over a coincident increment or capture.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sec_cnt_o  <= '0;
            ded_cnt_o  <= '0;
            ded_addr_o <= '0;
            ded_seen_o <= 1'b0;
        end else if (cnt_clr_i) begin
            sec_cnt_o  <= '0;
            ded_cnt_o  <= '0;
            ded_addr_o <= '0;
            ded_seen_o <= 1'b0;
        end else begin
            if (bus.out_valid && bus.sec && (sec_cnt_o != '1))
                sec_cnt_o <= sec_cnt_o + 1'b1;
            if (bus.out_valid && bus.ded && (ded_cnt_o != '1))
                ded_cnt_o <= ded_cnt_o + 1'b1;
            if (bus.out_valid && bus.ded && !ded_seen_o) begin
                ded_addr_o <= addr2;
                ded_seen_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ecc_secded_decoder.sv
// Directed bench for ecc_secded_decoder: vector table plus counter,
// saturation/clear and reset-in-flight sequences.
module tb_ecc_secded_decoder;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ecc_en_i;
    logic        cnt_clr_i;
    logic [1:0]  sec_cnt_o;
    logic [1:0]  ded_cnt_o;
    logic [15:0] ded_addr_o;
    logic        ded_seen_o;

    int checks = 0;
    int errors = 0;

    ecc_secded_decoder_if #(.ADDR_W(16)) bus ();

    ecc_secded_decoder #(.CNT_W(2), .ADDR_W(16)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .ecc_en_i   (ecc_en_i),
        .cnt_clr_i  (cnt_clr_i),
        .bus        (bus.slave),
        .sec_cnt_o  (sec_cnt_o),
        .ded_cnt_o  (ded_cnt_o),
        .ded_addr_o (ded_addr_o),
        .ded_seen_o (ded_seen_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        en;
        logic [39:0] raw;
        logic [15:0] addr;
        logic [39:0] exp_data;
        logic        exp_sec;
        logic        exp_ded;
    } vec_t;

    vec_t vecs [10];

    // Independent encoder: lay out codeword positions 1..38, then derive check bits.
    function automatic logic [39:0] enc(input logic [31:0] d);
        logic [38:0] c;
        logic [5:0]  p;
        logic [39:0] w;
        int          di;
        c  = '0;
        di = 0;
        for (int pos = 1; pos <= 38; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[di];
                di++;
            end
        end
        for (int k = 0; k < 6; k++) begin
            p[k] = 1'b0;
            for (int pos = 1; pos <= 38; pos++)
                if (((pos >> k) & 1) == 1) p[k] = p[k] ^ c[pos];
        end
        w = {2'b00, p, d};
        w[38] = ^w[37:0];
        return w;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input logic en, input logic [39:0] raw, input logic [15:0] addr,
                         input logic [39:0] exp_data, input logic exp_sec, input logic exp_ded,
                         input string tag);
        @(posedge clk_i); #1;
        ecc_en_i     = en;
        bus.rd_valid = 1'b1;
        bus.rd_addr  = addr;
        bus.raw_lo   = raw[19:0];
        bus.raw_hi   = raw[39:20];
        @(posedge clk_i); #1;
        bus.rd_valid = 1'b0;
        chk({tag, " out_valid early"}, 64'(bus.out_valid), 64'd0);
        @(posedge clk_i); #1;
        chk({tag, " out_valid"}, 64'(bus.out_valid), 64'd1);
        chk({tag, " data"}, 64'({bus.data_hi_ecc, bus.data_lo_ecc}), 64'(exp_data));
        chk({tag, " sec"}, 64'(bus.sec), 64'(exp_sec));
        chk({tag, " ded"}, 64'(bus.ded), 64'(exp_ded));
    endtask

    task automatic clear_counters();
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b1;
        @(posedge clk_i); #1;
        cnt_clr_i = 1'b0;
    endtask

    logic [39:0] raw0;
    logic [39:0] raw1;
    logic [39:0] sec_word;

    initial begin
        rst_n_i      = 1'b0;
        ecc_en_i     = 1'b1;
        cnt_clr_i    = 1'b0;
        bus.rd_valid = 1'b0;
        bus.rd_addr  = '0;
        bus.raw_lo   = '0;
        bus.raw_hi   = '0;

        raw0 = enc(32'hDEADBEEF);
        raw1 = enc(32'h12345678);
        vecs[0] = '{1'b1, raw0,                              16'h0100, raw0,                     1'b0, 1'b0};
        vecs[1] = '{1'b1, raw0 ^ (40'd1 << 5),               16'h0101, raw0,                     1'b1, 1'b0};
        vecs[2] = '{1'b1, raw0 ^ (40'd1 << 38),              16'h0102, raw0,                     1'b1, 1'b0};
        vecs[3] = '{1'b1, raw0 ^ (40'd1 << 33),              16'h0103, raw0,                     1'b1, 1'b0};
        vecs[4] = '{1'b1, raw0 ^ 40'd3,                      16'h0123, raw0 ^ 40'd3,             1'b0, 1'b1};
        vecs[5] = '{1'b1, raw0 | (40'd1 << 39),              16'h0105, raw0,                     1'b0, 1'b0};
        vecs[6] = '{1'b0, (raw0 ^ 40'd3) | (40'd1 << 39),    16'h0106, (raw0 ^ 40'd3) | (40'd1 << 39), 1'b0, 1'b0};
        vecs[7] = '{1'b1, raw0 ^ 40'h20_0000_0014,           16'h0107, raw0 ^ 40'h20_0000_0014,  1'b0, 1'b1};
        vecs[8] = '{1'b1, raw1 ^ (40'd1 << 31),              16'h0108, raw1,                     1'b1, 1'b0};
        vecs[9] = '{1'b1, raw0 ^ (40'd1 << 32),              16'h0109, raw0,                     1'b1, 1'b0};

        #2;
        chk("reset out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset data", 64'({bus.data_hi_ecc, bus.data_lo_ecc}), 64'd0);
        chk("reset sec_cnt", 64'(sec_cnt_o), 64'd0);
        chk("reset ded_seen", 64'(ded_seen_o), 64'd0);
        repeat (3) @(posedge clk_i);
        #1 rst_n_i = 1'b1;

        for (int i = 0; i < 10; i++)
            apply(vecs[i].en, vecs[i].raw, vecs[i].addr, vecs[i].exp_data,
                  vecs[i].exp_sec, vecs[i].exp_ded, $sformatf("vec%0d", i));
        @(posedge clk_i); #1;
        chk("table sec_cnt", 64'(sec_cnt_o), 64'd3);
        chk("table ded_cnt", 64'(ded_cnt_o), 64'd2);
        chk("table ded_addr", 64'(ded_addr_o), 64'h0123);
        chk("table ded_seen", 64'(ded_seen_o), 64'd1);

        // Two DEDs: address of the first one sticks.
        clear_counters();
        chk("clr sec_cnt", 64'(sec_cnt_o), 64'd0);
        chk("clr ded_seen", 64'(ded_seen_o), 64'd0);
        apply(1'b1, raw0 ^ 40'd3, 16'h0123, raw0 ^ 40'd3, 1'b0, 1'b1, "ded1");
        apply(1'b1, raw0 ^ 40'd3, 16'h0456, raw0 ^ 40'd3, 1'b0, 1'b1, "ded2");
        @(posedge clk_i); #1;
        chk("ded ded_cnt", 64'(ded_cnt_o), 64'd2);
        chk("ded ded_addr", 64'(ded_addr_o), 64'h0123);
        chk("ded ded_seen", 64'(ded_seen_o), 64'd1);
        chk("ded sec_cnt", 64'(sec_cnt_o), 64'd0);

        // Back-to-back SEC reads: saturation, then clear against a 6th increment.
        clear_counters();
        sec_word = raw0 ^ (40'd1 << 5);
        for (int c = 0; c < 9; c++) begin
            @(posedge clk_i); #1;
            case (c)
                3: chk("sat cnt1", 64'(sec_cnt_o), 64'd1);
                4: chk("sat cnt2", 64'(sec_cnt_o), 64'd2);
                5: chk("sat cnt3", 64'(sec_cnt_o), 64'd3);
                6: chk("sat cnt4", 64'(sec_cnt_o), 64'd3);
                7: begin
                    chk("sat cnt5", 64'(sec_cnt_o), 64'd3);
                    chk("sat sec6", 64'(bus.sec), 64'd1);
                end
                8: chk("clr wins", 64'(sec_cnt_o), 64'd0);
                default: ;
            endcase
            if (c >= 2 && c <= 7)
                chk($sformatf("b2b data %0d", c), 64'({bus.data_hi_ecc, bus.data_lo_ecc}), 64'(raw0));
            ecc_en_i     = 1'b1;
            bus.rd_valid = (c < 6);
            bus.rd_addr  = 16'(16'h0200 + c);
            bus.raw_lo   = sec_word[19:0];
            bus.raw_hi   = sec_word[39:20];
            cnt_clr_i    = (c == 7);
        end
        cnt_clr_i    = 1'b0;
        bus.rd_valid = 1'b0;

        // Reset with one word on the output and another in stage 1.
        @(posedge clk_i); #1;
        bus.rd_valid = 1'b1;
        bus.raw_lo   = raw0[19:0];
        bus.raw_hi   = raw0[39:20];
        @(posedge clk_i); #1;
        bus.raw_lo   = sec_word[19:0];
        bus.raw_hi   = sec_word[39:20];
        @(posedge clk_i); #1;
        bus.rd_valid = 1'b0;
        chk("rst pre out_valid", 64'(bus.out_valid), 64'd1);
        rst_n_i = 1'b0;
        #1;
        chk("rst out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst data", 64'({bus.data_hi_ecc, bus.data_lo_ecc}), 64'd0);
        chk("rst sec", 64'(bus.sec), 64'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk_i); #1;
            chk($sformatf("post rst stale %0d", c), 64'(bus.out_valid), 64'd0);
        end
        apply(1'b1, raw1, 16'h0300, raw1, 1'b0, 1'b0, "post rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
